alu_share_arb: RTL

- Shares one combinational ALU between two requesters, req0 and req1.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Drives the ALU operands and control code, then captures the result and zero flag into a 1-entry response register that carries a requester ID.
- Sits between the decode/issue logic and the shared ALU instance in the small MIPS datapath.

---
 rtl/alu_share_arb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// Two-port round-robin front end for one shared combinational ALU, with a 1-entry tagged response register.
// Latency: result, zero flag and requester ID are registered one cycle after acceptance; 1 op/cycle sustained.
// Backpressure: a held response that is not being drained blocks both requesters. Optional macro: ALU_CTRL_CHECK_EN.
module alu_share_arb #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    input  logic [WIDTH-1:0] i_req0_op1,
    input  logic [WIDTH-1:0] i_req0_op2,
    input  logic [3:0]       i_req0_control,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [WIDTH-1:0] i_req1_op1,
    input  logic [WIDTH-1:0] i_req1_op2,
    input  logic [3:0]       i_req1_control,
    output logic             o_req1_ready,
    output logic [WIDTH-1:0] o_alu_op1,
    output logic [WIDTH-1:0] o_alu_op2,
    output logic [3:0]       o_alu_control,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_zf,
    output logic             o_rsp_valid,
    output logic             o_rsp_id,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic             o_rsp_zf,
`ifdef ALU_CTRL_CHECK_EN
    output logic             o_rsp_err,
`endif
    input  logic             i_rsp_ready
);

    localparam logic [3:0] CTRL_AND = 4'b0000;

`ifdef ALU_CTRL_CHECK_EN
    // Only the six codes the ALU implements are considered legal.
    function automatic logic ctrl_legal(input logic [3:0] c);
        case (c)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: ctrl_legal = 1'b1;
            default:                                              ctrl_legal = 1'b0;
        endcase
    endfunction
`endif

    logic             rsp_valid_q,  rsp_valid_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zf_q,     rsp_zf_d;
    logic             last_grant_q, last_grant_d;
`ifdef ALU_CTRL_CHECK_EN
    logic             rsp_err_q,    rsp_err_d;
`endif

    logic             slot_free;
    logic             grant0;
    logic             grant1;
    logic             transfer;
    logic             alu_drive;
    logic [WIDTH-1:0] sel_op1;
    logic [WIDTH-1:0] sel_op2;
    logic [3:0]       sel_control;

    // Round-robin grant: a lone requester wins; under contention the one not granted last wins.
    always_comb begin
        slot_free = !rsp_valid_q || i_rsp_ready;
        grant0    = slot_free && i_req0_valid && (!i_req1_valid || last_grant_q);
        grant1    = slot_free && i_req1_valid && (!i_req0_valid || !last_grant_q);
        transfer  = grant0 || grant1;
    end

    // Steer the granted operands to the ALU; idle or rejected codes present zeros and AND.
    always_comb begin
        sel_op1     = grant1 ? i_req1_op1     : i_req0_op1;
        sel_op2     = grant1 ? i_req1_op2     : i_req0_op2;
        sel_control = grant1 ? i_req1_control : i_req0_control;
`ifdef ALU_CTRL_CHECK_EN
        alu_drive   = transfer && ctrl_legal(sel_control);
`else
        alu_drive   = transfer;
`endif
        o_alu_op1     = alu_drive ? sel_op1     : '0;
        o_alu_op2     = alu_drive ? sel_op2     : '0;
        o_alu_control = alu_drive ? sel_control : CTRL_AND;
    end

    // Response slot next state: capture on transfer (drain and refill share a cycle), clear valid on a bare drain.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zf_d     = rsp_zf_q;
        last_grant_d = last_grant_q;
`ifdef ALU_CTRL_CHECK_EN
        rsp_err_d    = rsp_err_q;
`endif
        if (transfer) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant1;
            rsp_result_d = i_alu_result;
            rsp_zf_d     = i_alu_zf;
            last_grant_d = grant1;
`ifdef ALU_CTRL_CHECK_EN
            // Zero flag is forced low too: the ALU sees AND 0,0 and would report zero.
            rsp_err_d    = !alu_drive;
            if (!alu_drive) begin
                rsp_result_d = '0;
                rsp_zf_d     = 1'b0;
            end
`endif
        end else if (i_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers; last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zf_q     <= 1'b0;
            last_grant_q <= 1'b1;
`ifdef ALU_CTRL_CHECK_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zf_q     <= rsp_zf_d;
            last_grant_q <= last_grant_d;
`ifdef ALU_CTRL_CHECK_EN
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_zf     = rsp_zf_q;
`ifdef ALU_CTRL_CHECK_EN
    assign o_rsp_err    = rsp_err_q;
`endif

endmodule
